// File: rtl/fnd_pkg.sv
// Shared types and constants for the FND scan controller: FSM state encoding,
// active-low segment codes {dp,g,f,e,d,c,b,a}, display saturation limit.
// No logic, no latency; no handshake (constants and one pure helper only).
package fnd_pkg;

  localparam int COUNT_W = 14;
  localparam logic [COUNT_W-1:0] MAX_COUNT = 14'd9999;

  typedef enum logic [1:0] {
    ST_OFF   = 2'd0,
    ST_BLANK = 2'd1,
    ST_DRIVE = 2'd2
  } fnd_state_e;

  // Segment codes with the dp bit (bit 7) off.
  localparam logic [7:0] SEG_0     = 8'hC0;
  localparam logic [7:0] SEG_1     = 8'hF9;
  localparam logic [7:0] SEG_2     = 8'hA4;
  localparam logic [7:0] SEG_3     = 8'hB0;
  localparam logic [7:0] SEG_4     = 8'h99;
  localparam logic [7:0] SEG_5     = 8'h92;
  localparam logic [7:0] SEG_6     = 8'h82;
  localparam logic [7:0] SEG_7     = 8'hF8;
  localparam logic [7:0] SEG_8     = 8'h80;
  localparam logic [7:0] SEG_9     = 8'h90;
  localparam logic [7:0] SEG_BLANK = 8'hFF;

  // Values beyond four decimal digits are shown as 9999.
  function automatic logic [COUNT_W-1:0] saturate_count(input logic [COUNT_W-1:0] v);
    return (v > MAX_COUNT) ? MAX_COUNT : v;
  endfunction

endpackage

// File: rtl/fnd_scan_ctrl_if.sv
// Bundle between the counter datapath / board pins and the scan controller.
// Latency: n/a (wires only). Backpressure: none, display pins are free-running.
// Ports: en, count_in, dp_in (to controller); fnd_com, fnd_data, frame_done (from it).
interface fnd_scan_ctrl_if;
  import fnd_pkg::*;

  logic               en;
  logic [COUNT_W-1:0] count_in;
  logic [3:0]         dp_in;
  logic [3:0]         fnd_com;
  logic [7:0]         fnd_data;
  logic               frame_done;

  // master: the side supplying the value to show and observing the pins.
  modport master (
    output en, count_in, dp_in,
    input  fnd_com, fnd_data, frame_done
  );

  // slave: the scan controller itself.
  modport slave (
    input  en, count_in, dp_in,
    output fnd_com, fnd_data, frame_done
  );

endinterface

// File: rtl/fnd_seg_decode.sv
// BCD digit to 7-segment active-low code {g,f,e,d,c,b,a}; non-decimal input blanks.
// Latency: combinational. Backpressure: none.
// Ports: digit (4-bit BCD in), seg (7-bit active-low segments out).
module fnd_seg_decode
  import fnd_pkg::*;
(
  input  logic [3:0] digit,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_BLANK[6:0];
    case (digit)
      4'd0:    seg = SEG_0[6:0];
      4'd1:    seg = SEG_1[6:0];
      4'd2:    seg = SEG_2[6:0];
      4'd3:    seg = SEG_3[6:0];
      4'd4:    seg = SEG_4[6:0];
      4'd5:    seg = SEG_5[6:0];
      4'd6:    seg = SEG_6[6:0];
      4'd7:    seg = SEG_7[6:0];
      4'd8:    seg = SEG_8[6:0];
      4'd9:    seg = SEG_9[6:0];
      default: seg = SEG_BLANK[6:0];
    endcase
  end

endmodule

// File: rtl/fnd_scan_ctrl.sv
// 4-digit common-anode FND scanner: one slot per digit, blank phase then drive phase.
// Latency: outputs registered; value sampled at frame start, shown from the next DRIVE.
// Backpressure: none; en=0 parks the scanner in OFF with the display dark.
// Ports: clk, reset (async active-low), bus (fnd_scan_ctrl_if.slave).
// Optional build macro FND_LZB_EN: blank leading zeros on thousands/hundreds/tens.
// BLANK_CYC must be at least 1 and below CLK_HZ/SCAN_HZ.
module fnd_scan_ctrl
  import fnd_pkg::*;
#(
  parameter int CLK_HZ    = 100_000_000,
  parameter int SCAN_HZ   = 1000,
  parameter int BLANK_CYC = 100
) (
  input logic           clk,
  input logic           reset,
  fnd_scan_ctrl_if.slave bus
);

  localparam int SLOT_CYC = CLK_HZ / SCAN_HZ;
  localparam int CNT_W    = (SLOT_CYC > 1) ? $clog2(SLOT_CYC) : 1;
  localparam logic [CNT_W-1:0] CNT_SLOT_LAST  = CNT_W'(SLOT_CYC - 1);
  localparam logic [CNT_W-1:0] CNT_BLANK_LAST = CNT_W'(BLANK_CYC - 1);

  fnd_state_e         state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [1:0]         digit_q, digit_d;
  logic [COUNT_W-1:0] val_q, val_d;
  logic [3:0]         dp_q, dp_d;
  logic [3:0]         com_q, com_d;
  logic [7:0]         data_q, data_d;
  logic               fd_q, fd_d;

  logic [3:0]         dig [4];
  logic [3:0]         cur_digit;
  logic [6:0]         seg_raw;
  logic [6:0]         seg;

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_OFF;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    digit_d = digit_q;
    val_d   = val_q;
    dp_d    = dp_q;
    if (!bus.en) begin
      // Disable overrides every transition, including a slot end on the same edge.
      state_d = ST_OFF;
      cnt_d   = '0;
      digit_d = 2'd0;
    end else begin
      case (state_q)
        ST_OFF: begin
          state_d = ST_BLANK;
          cnt_d   = '0;
          digit_d = 2'd0;
          val_d   = saturate_count(bus.count_in);
          dp_d    = bus.dp_in;
        end
        ST_BLANK: begin
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_BLANK_LAST) begin
            state_d = ST_DRIVE;
          end
        end
        ST_DRIVE: begin
          if (cnt_q == CNT_SLOT_LAST) begin
            state_d = ST_BLANK;
            cnt_d   = '0;
            digit_d = digit_q + 2'd1;
            // Wrapping back to digit 0 starts a new frame: take a fresh snapshot.
            if (digit_q == 2'd3) begin
              val_d = saturate_count(bus.count_in);
              dp_d  = bus.dp_in;
            end
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        default: begin
          state_d = ST_OFF;
          cnt_d   = '0;
          digit_d = 2'd0;
        end
      endcase
    end
  end

  // ------------------------------------------------------- digit split
  // Only the latched value feeds the split, so mid-frame input changes never tear.
  always_comb begin
    dig[0] = 4'(val_q % COUNT_W'(10));
    dig[1] = 4'((val_q / COUNT_W'(10)) % COUNT_W'(10));
    dig[2] = 4'((val_q / COUNT_W'(100)) % COUNT_W'(10));
    dig[3] = 4'(val_q / COUNT_W'(1000));
  end

  // Outputs are registered alongside the state, so decode the digit of the next state.
  always_comb begin
    cur_digit = dig[digit_d];
  end

  fnd_seg_decode u_seg_decode (
    .digit (cur_digit),
    .seg   (seg_raw)
  );

`ifdef FND_LZB_EN
  logic [3:0] lead_zero;

  // A digit is a leading zero when it and every more significant digit are 0.
  // The ones digit is never blanked.
  always_comb begin
    lead_zero[3] = (dig[3] == 4'd0);
    lead_zero[2] = lead_zero[3] && (dig[2] == 4'd0);
    lead_zero[1] = lead_zero[2] && (dig[1] == 4'd0);
    lead_zero[0] = 1'b0;
    seg = lead_zero[digit_d] ? SEG_BLANK[6:0] : seg_raw;
  end
`else
  always_comb begin
    seg = seg_raw;
  end
`endif

  // ---------------------------------------------------------- outputs
  always_comb begin
    com_d  = 4'hF;
    data_d = SEG_BLANK;
    fd_d   = 1'b0;
    if (state_d == ST_DRIVE) begin
      com_d  = ~(4'b0001 << digit_d);
      data_d = {~dp_q[digit_d], seg};
      fd_d   = (digit_d == 2'd3) && (cnt_d == CNT_SLOT_LAST);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q   <= '0;
      digit_q <= 2'd0;
      val_q   <= '0;
      dp_q    <= 4'd0;
      com_q   <= 4'hF;
      data_q  <= SEG_BLANK;
      fd_q    <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      digit_q <= digit_d;
      val_q   <= val_d;
      dp_q    <= dp_d;
      com_q   <= com_d;
      data_q  <= data_d;
      fd_q    <= fd_d;
    end
  end

  assign bus.fnd_com    = com_q;
  assign bus.fnd_data   = data_q;
  assign bus.frame_done = fd_q;

endmodule

// File: tb/tb_fnd_scan_ctrl.sv
// Bench for fnd_scan_ctrl with a 10-cycle slot (2 blank + 8 drive), 40-cycle frame.
// Expected pin values are queued per cycle from a frame model and popped at negedge.
// Honors FND_LZB_EN the same way the design does.
module tb_fnd_scan_ctrl;

  localparam int SLOT = 10;
  localparam int BLK  = 2;
  localparam int FRAME = 4 * SLOT;

  typedef struct packed {
    logic [3:0] com;
    logic [7:0] data;
    logic       fd;
  } obs_t;

  logic clk;
  logic reset;

  fnd_scan_ctrl_if bus ();

  fnd_scan_ctrl #(
    .CLK_HZ    (1000),
    .SCAN_HZ   (100),
    .BLANK_CYC (BLK)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  obs_t exp_q [$];
  int   n_pass   = 0;
  int   n_checks = 0;

  logic [7:0] seg_tab [10] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99,
                               8'h92, 8'h82, 8'hF8, 8'h80, 8'h90};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got no summary, want finish");
    $fatal(1, "watchdog expired");
  end

  function automatic obs_t cur_obs();
    obs_t o;
    o.com  = bus.fnd_com;
    o.data = bus.fnd_data;
    o.fd   = bus.frame_done;
    return o;
  endfunction

  function automatic void push_idle(input int n);
    obs_t o;
    o.com  = 4'hF;
    o.data = 8'hFF;
    o.fd   = 1'b0;
    for (int j = 0; j < n; j++) exp_q.push_back(o);
  endfunction

  // Expected pins for the first n cycles of a frame that latched (val, dp).
  function automatic void push_frame(input int val, input logic [3:0] dp, input int n);
    int         v;
    int         slot;
    int         w;
    int         dg [4];
    logic [7:0] code;
    logic [3:0] one;
    obs_t       o;
    v = (val > 9999) ? 9999 : val;
    dg[0] = v % 10;
    dg[1] = (v / 10) % 10;
    dg[2] = (v / 100) % 10;
    dg[3] = v / 1000;
    one = 4'b0001;
    for (int j = 0; j < n; j++) begin
      slot = j / SLOT;
      w    = j % SLOT;
      if (w < BLK) begin
        o.com  = 4'hF;
        o.data = 8'hFF;
        o.fd   = 1'b0;
      end else begin
        code = seg_tab[dg[slot]];
`ifdef FND_LZB_EN
        begin : lzb
          bit lead;
          lead = 1'b1;
          for (int k = slot; k < 4; k++) if (dg[k] != 0) lead = 1'b0;
          if (slot != 0 && lead) code = 8'hFF;
        end
`endif
        if (dp[slot]) code[7] = 1'b0;
        o.com  = ~(one << slot);
        o.data = code;
        o.fd   = (slot == 3) && (w == SLOT - 1);
      end
      exp_q.push_back(o);
    end
  endfunction

  task automatic test_reset();
    obs_t got;
    obs_t e;
    reset        = 1'b0;
    bus.en       = 1'b0;
    bus.count_in = '0;
    bus.dp_in    = 4'd0;
    repeat (3) @(negedge clk);
    got = cur_obs();
    n_checks++;
    if (got !== 13'h1FFE)
      $display("FAIL reset_state: com/data/fd got %h/%h/%b want f/ff/0", got.com, got.data, got.fd);
    else n_pass++;
    reset = 1'b1;
    push_idle(5);
    repeat (5) begin
      @(negedge clk);
      got = cur_obs();
      e = exp_q.pop_front();
      n_checks++;
      if (got !== e)
        $display("FAIL off_idle: got %h/%h/%b want %h/%h/%b", got.com, got.data, got.fd, e.com, e.data, e.fd);
      else n_pass++;
    end
  endtask

  task automatic test_basic_scan();
    obs_t got;
    obs_t e;
    int   fd_cnt;
    fd_cnt = 0;
    bus.count_in = 14'd1234;
    bus.dp_in    = 4'd0;
    bus.en       = 1'b1;
    push_frame(1234, 4'd0, FRAME);
    push_frame(1234, 4'd0, FRAME);
    repeat (2 * FRAME) begin
      @(negedge clk);
      got = cur_obs();
      e = exp_q.pop_front();
      if (got.fd) fd_cnt++;
      n_checks++;
      if (got !== e)
        $display("FAIL basic_scan: got %h/%h/%b want %h/%h/%b", got.com, got.data, got.fd, e.com, e.data, e.fd);
      else n_pass++;
    end
    n_checks++;
    if (fd_cnt !== 2)
      $display("FAIL frame_done_count: got %0d pulses want 2", fd_cnt);
    else n_pass++;
  endtask

  task automatic test_saturation_dp();
    obs_t       got;
    obs_t       e;
    int         vals [4] = '{12000, 16383, 9999, 10000};
    logic [3:0] dps  [4] = '{4'b0100, 4'b0000, 4'b1001, 4'b0000};
    for (int t = 0; t < 4; t++) begin
      bus.count_in = 14'(vals[t]);
      bus.dp_in    = dps[t];
      push_frame(vals[t], dps[t], FRAME);
      repeat (FRAME) begin
        @(negedge clk);
        got = cur_obs();
        e = exp_q.pop_front();
        n_checks++;
        if (got !== e)
          $display("FAIL saturation_dp(%0d): got %h/%h/%b want %h/%h/%b", vals[t],
                   got.com, got.data, got.fd, e.com, e.data, e.fd);
        else n_pass++;
      end
    end
    bus.dp_in = 4'd0;
  endtask

  task automatic test_mid_frame_update();
    obs_t got;
    obs_t e;
    bus.count_in = 14'd1234;
    push_frame(1234, 4'd0, FRAME);
    push_frame(5678, 4'd0, FRAME);
    for (int j = 0; j < 2 * FRAME; j++) begin
      @(negedge clk);
      got = cur_obs();
      e = exp_q.pop_front();
      n_checks++;
      if (got !== e)
        $display("FAIL mid_frame_update: cyc %0d got %h/%h/%b want %h/%h/%b", j,
                 got.com, got.data, got.fd, e.com, e.data, e.fd);
      else n_pass++;
      if (j == 15) bus.count_in = 14'd5678;
    end
  endtask

  task automatic test_enable_gating();
    obs_t got;
    obs_t e;
    bus.count_in = 14'd4321;
    push_frame(4321, 4'd0, 25);
    repeat (25) begin
      @(negedge clk);
      got = cur_obs();
      e = exp_q.pop_front();
      n_checks++;
      if (got !== e)
        $display("FAIL enable_pre: got %h/%h/%b want %h/%h/%b", got.com, got.data, got.fd, e.com, e.data, e.fd);
      else n_pass++;
    end
    bus.en = 1'b0;
    push_idle(15);
    repeat (15) begin
      @(negedge clk);
      got = cur_obs();
      e = exp_q.pop_front();
      n_checks++;
      if (got !== e)
        $display("FAIL enable_off: got %h/%h/%b want %h/%h/%b", got.com, got.data, got.fd, e.com, e.data, e.fd);
      else n_pass++;
    end
    bus.en       = 1'b1;
    bus.count_in = 14'd1234;
    push_frame(1234, 4'd0, FRAME);
    repeat (FRAME) begin
      @(negedge clk);
      got = cur_obs();
      e = exp_q.pop_front();
      n_checks++;
      if (got !== e)
        $display("FAIL enable_restart: got %h/%h/%b want %h/%h/%b", got.com, got.data, got.fd, e.com, e.data, e.fd);
      else n_pass++;
    end
  endtask

  task automatic test_async_reset();
    obs_t got;
    obs_t e;
    bus.count_in = 14'd5678;
    push_frame(5678, 4'd0, 15);
    repeat (15) begin
      @(negedge clk);
      got = cur_obs();
      e = exp_q.pop_front();
      n_checks++;
      if (got !== e)
        $display("FAIL areset_pre: got %h/%h/%b want %h/%h/%b", got.com, got.data, got.fd, e.com, e.data, e.fd);
      else n_pass++;
    end
    #1 reset = 1'b0;
    #1;
    got = cur_obs();
    n_checks++;
    if (got !== 13'h1FFE)
      $display("FAIL areset_immediate: got %h/%h/%b want f/ff/0", got.com, got.data, got.fd);
    else n_pass++;
    @(negedge clk);
    reset = 1'b1;
    push_frame(5678, 4'd0, FRAME);
    repeat (FRAME) begin
      @(negedge clk);
      got = cur_obs();
      e = exp_q.pop_front();
      n_checks++;
      if (got !== e)
        $display("FAIL areset_restart: got %h/%h/%b want %h/%h/%b", got.com, got.data, got.fd, e.com, e.data, e.fd);
      else n_pass++;
    end
  endtask

  task automatic test_leading_zero();
    obs_t got;
    obs_t e;
    bus.count_in = 14'd7;
    push_frame(7, 4'd0, FRAME);
    repeat (FRAME) begin
      @(negedge clk);
      got = cur_obs();
      e = exp_q.pop_front();
      n_checks++;
      if (got !== e)
        $display("FAIL leading_zero: got %h/%h/%b want %h/%h/%b", got.com, got.data, got.fd, e.com, e.data, e.fd);
      else n_pass++;
    end
  endtask

  initial begin
    test_reset();
    test_basic_scan();
    test_saturation_dp();
    test_mid_frame_update();
    test_enable_gating();
    test_async_reset();
    test_leading_zero();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
